// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// MEM-stage access controller for the pipelined MIPS core. It sits between the
// EX/MEM pipeline register and data_mem_64x32 (64 x 32-bit words, 256 bytes)
// and turns byte-addressed loads and stores into word-wide memory accesses.
//   - LB/LBU/LH/LHU/LW : one cycle; the lane is picked from mem_rd on the accept
//                        edge, then extended into the registered wb_data.
//   - SW               : one cycle; the word is written straight to memory.
//   - SB/SH            : two-cycle read-modify-write. Cycle A reads the word
//                        into merge_buf. Cycle B (RMW_WR) writes the merged word
//                        and holds upstream through stall.
// Byte order is big-endian: byte offset 0 is bits [31:24].
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   req_valid          EX/MEM holds a memory instruction
//   req_is_store       1 = store, 0 = load
//   req_size           00 byte, 01 half, 10 word, 11 illegal (faults)
//   req_unsigned       zero-extend loads (LBU/LHU)
//   req_addr           byte address
//   req_wdata          store data (low byte/half/word used)
//   req_rd_idx         destination register index
//   stall              upstream must hold its request (state RMW_WR only)
//   mem_addr           word index to memory
//   mem_wd             write word to memory
//   mem_rd             read word from memory (combinational from mem_addr)
//   mem_write          memory write enable
//   mem_read           memory read enable
//   wb_valid           registered: MEM/WB slot holds a completed instruction
//   wb_is_load         registered: wb_data must be written to wb_rd_idx
//   wb_data            registered: extended load data (0 for stores)
//   wb_rd_idx          registered: destination index
//   fault              registered one-cycle pulse on a bad access
//   fault_addr         registered: address of the last faulting request
// -----------------------------------------------------------------------------
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_is_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd_idx,
  output logic        stall,
  output logic [5:0]  mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  output logic        mem_write,
  output logic        mem_read,
  output logic        wb_valid,
  output logic        wb_is_load,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd_idx,
  output logic        fault,
  output logic [31:0] fault_addr
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RMW_WR = 1'b1
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  state_e state_q, state_d;

  // Registered MEM/WB and fault outputs.
  logic        wb_valid_q;
  logic        wb_is_load_q;
  logic [31:0] wb_data_q;
  logic [4:0]  wb_rd_idx_q;
  logic        fault_q;
  logic [31:0] fault_addr_q;

  // Sub-word store context captured in cycle A, consumed in cycle B.
  logic [31:0] merge_buf_q;
  logic [5:0]  lat_idx_q;
  logic [1:0]  lat_off_q;
  logic        lat_half_q;
  logic [15:0] lat_wdata_q;
  logic [4:0]  lat_rd_q;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic accept;
  logic range_err;
  logic size_err;
  logic align_err;
  logic req_fault;
  logic req_ok;
  logic do_load;
  logic do_sw;
  logic do_sub;

  assign accept    = req_valid && (state_q == ST_IDLE) && !rst;
  assign range_err = |req_addr[31:8];
  assign size_err  = (req_size == SIZE_ILL);
  assign align_err = ((req_size == SIZE_HALF) && req_addr[0]) ||
                     ((req_size == SIZE_WORD) && (|req_addr[1:0]));
  assign req_fault = accept && (range_err || size_err || align_err);
  assign req_ok    = accept && !(range_err || size_err || align_err);
  assign do_load   = req_ok && !req_is_store;
  assign do_sw     = req_ok && req_is_store && (req_size == SIZE_WORD);
  // Size 11 has already been filtered out as a fault, so !size[1] is byte/half.
  assign do_sub    = req_ok && req_is_store && !req_size[1];

  // ---------------------------------------------------------------------------
  // Load lane selection and extension (big-endian lanes)
  // ---------------------------------------------------------------------------
  logic [7:0]  rd_byte [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rd_lane
      // Lane gi is byte offset gi, so offset 0 is the most significant byte.
      assign rd_byte[gi] = mem_rd[31-8*gi -: 8];
    end
  endgenerate

  assign byte_sel = rd_byte[req_addr[1:0]];
  assign half_sel = req_addr[1] ? mem_rd[15:0] : mem_rd[31:16];

  always_comb begin
    load_ext = mem_rd;
    case (req_size)
      SIZE_BYTE: load_ext = req_unsigned ? {24'h0, byte_sel}
                                         : {{24{byte_sel[7]}}, byte_sel};
      SIZE_HALF: load_ext = req_unsigned ? {16'h0, half_sel}
                                         : {{16{half_sel[15]}}, half_sel};
      default:   load_ext = mem_rd;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read-modify-write merge: replace the target lane(s) of merge_buf
  // ---------------------------------------------------------------------------
  logic [31:0] merge_word;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic       lane_hit;
      logic [7:0] lane_new;
      // A half covers lanes {0,1} or {2,3}, selected by offset bit 1.
      assign lane_hit = lat_half_q ? (lat_off_q[1] == LANE[1])
                                   : (lat_off_q == LANE);
      // Within a half, the even lane carries the upper byte of the store data.
      assign lane_new = (lat_half_q && !LANE[0]) ? lat_wdata_q[15:8]
                                                 : lat_wdata_q[7:0];
      assign merge_word[31-8*gi -: 8] = lane_hit ? lane_new
                                                 : merge_buf_q[31-8*gi -: 8];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (do_sub) state_d = ST_RMW_WR;
      ST_RMW_WR: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    stall     = 1'b0;
    mem_addr  = req_addr[7:2];
    mem_wd    = 32'h0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Accept terms already include !rst, so reset blocks both strobes.
        mem_read  = do_load || do_sub;
        mem_write = do_sw;
        if (do_sw) mem_wd = req_wdata;
      end
      ST_RMW_WR: begin
        stall     = 1'b1;
        mem_addr  = lat_idx_q;
        mem_wd    = merge_word;
        // Reset in cycle B abandons the write.
        mem_write = !rst;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers: MEM/WB slot, fault reporting, RMW context
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q   <= 1'b0;
      wb_is_load_q <= 1'b0;
      wb_data_q    <= 32'h0;
      wb_rd_idx_q  <= 5'h0;
      fault_q      <= 1'b0;
      fault_addr_q <= 32'h0;
      merge_buf_q  <= 32'h0;
      lat_idx_q    <= 6'h0;
      lat_off_q    <= 2'h0;
      lat_half_q   <= 1'b0;
      lat_wdata_q  <= 16'h0;
      lat_rd_q     <= 5'h0;
    end else begin
      wb_valid_q <= 1'b0;
      fault_q    <= 1'b0;

      if (do_load) begin
        wb_valid_q   <= 1'b1;
        wb_is_load_q <= 1'b1;
        wb_data_q    <= load_ext;
        wb_rd_idx_q  <= req_rd_idx;
      end

      if (do_sw) begin
        wb_valid_q   <= 1'b1;
        wb_is_load_q <= 1'b0;
        wb_data_q    <= 32'h0;
        wb_rd_idx_q  <= req_rd_idx;
      end

      if (do_sub) begin
        merge_buf_q <= mem_rd;
        lat_idx_q   <= req_addr[7:2];
        lat_off_q   <= req_addr[1:0];
        lat_half_q  <= (req_size == SIZE_HALF);
        lat_wdata_q <= req_wdata[15:0];
        lat_rd_q    <= req_rd_idx;
      end

      if (req_fault) begin
        fault_q      <= 1'b1;
        fault_addr_q <= req_addr;
      end

      // Completion of the sub-word store at the edge ending cycle B.
      if (state_q == ST_RMW_WR) begin
        wb_valid_q   <= 1'b1;
        wb_is_load_q <= 1'b0;
        wb_data_q    <= 32'h0;
        wb_rd_idx_q  <= lat_rd_q;
      end
    end
  end

  assign wb_valid   = wb_valid_q;
  assign wb_is_load = wb_is_load_q;
  assign wb_data    = wb_data_q;
  assign wb_rd_idx  = wb_rd_idx_q;
  assign fault      = fault_q;
  assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Self-checking bench for mem_access_unit. A 64-word memory model stands in for
// data_mem_64x32; a separate reference copy of memory is updated from plain
// byte-lane arithmetic and used to predict load results and stored words.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_is_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd_idx;
  logic        stall;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        mem_write;
  logic        mem_read;
  logic        wb_valid;
  logic        wb_is_load;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd_idx;
  logic        fault;
  logic [31:0] fault_addr;

  mem_access_unit dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_is_store (req_is_store),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_rd_idx   (req_rd_idx),
    .stall        (stall),
    .mem_addr     (mem_addr),
    .mem_wd       (mem_wd),
    .mem_rd       (mem_rd),
    .mem_write    (mem_write),
    .mem_read     (mem_read),
    .wb_valid     (wb_valid),
    .wb_is_load   (wb_is_load),
    .wb_data      (wb_data),
    .wb_rd_idx    (wb_rd_idx),
    .fault        (fault),
    .fault_addr   (fault_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory seen by the DUT.
  logic [31:0] tb_mem [64];
  always @(posedge clk) begin
    if (mem_write) tb_mem[mem_addr] <= mem_wd;
  end
  assign mem_rd = mem_read ? tb_mem[mem_addr] : 32'hA5A5_A5A5;

  // Reference memory, updated only by the model.
  logic [31:0] ref_mem [64];

  int checks;
  int failures;
  int txn_errs;
  int txn_no;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      txn_errs++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Shift (in bits) that brings a big-endian lane down to bit 0.
  function automatic int lane_shift(input logic [1:0] sz, input logic [1:0] off);
    int o;
    o = int'(off);
    return (sz == 2'b00) ? 8 * (3 - o) : 8 * (2 - o);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] off, input logic un);
    logic [31:0] v;
    if (sz == 2'b00) begin
      v = (w >> lane_shift(sz, off)) & 32'hFF;
      if (!un && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = (w >> lane_shift(sz, off)) & 32'hFFFF;
      if (!un && v >= 32'd32768) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] off, input logic [31:0] wd);
    logic [31:0] lowmask;
    logic [31:0] mask;
    int sh;
    lowmask = (sz == 2'b00) ? 32'hFF : 32'hFFFF;
    sh      = lane_shift(sz, off);
    mask    = lowmask << sh;
    return (w & ~mask) | ((wd & lowmask) << sh);
  endfunction

  function automatic logic is_bad(input logic [1:0] sz, input logic [31:0] ad);
    return (ad[31:8] != 24'h0) || (sz == 2'b11) ||
           (sz == 2'b01 && ad[0]) || (sz == 2'b10 && ad[1:0] != 2'b00);
  endfunction

  // Issue one request starting just after a rising edge and run it to
  // completion. has_exp adds a check against a fixed value: the load result,
  // the stored word, or the fault address, depending on the request kind.
  task automatic issue(input logic st, input logic [1:0] sz, input logic un,
                       input logic [31:0] ad, input logic [31:0] wd, input logic [4:0] rd,
                       input logic has_exp, input logic [31:0] exp_val);
    logic        bad;
    logic [5:0]  idx;
    logic [31:0] exp_ld;
    logic [31:0] merged;
    bad      = is_bad(sz, ad);
    idx      = ad[7:2];
    exp_ld   = ref_load(ref_mem[idx], sz, ad[1:0], un);
    txn_errs = 0;

    req_valid    = 1'b1;
    req_is_store = st;
    req_size     = sz;
    req_unsigned = un;
    req_addr     = ad;
    req_wdata    = wd;
    req_rd_idx   = rd;
    #4;
    chk("stall_accept", 32'(stall), 32'h0);
    if (bad) begin
      chk("flt_mem_read", 32'(mem_read), 32'h0);
      chk("flt_mem_write", 32'(mem_write), 32'h0);
    end else if (!st) begin
      chk("ld_mem_read", 32'(mem_read), 32'h1);
      chk("ld_mem_write", 32'(mem_write), 32'h0);
      chk("ld_mem_addr", 32'(mem_addr), 32'(idx));
    end else if (sz == 2'b10) begin
      chk("sw_mem_write", 32'(mem_write), 32'h1);
      chk("sw_mem_read", 32'(mem_read), 32'h0);
      chk("sw_mem_addr", 32'(mem_addr), 32'(idx));
      chk("sw_mem_wd", mem_wd, wd);
    end else begin
      chk("rmwa_mem_read", 32'(mem_read), 32'h1);
      chk("rmwa_mem_write", 32'(mem_write), 32'h0);
      chk("rmwa_mem_addr", 32'(mem_addr), 32'(idx));
    end

    @(posedge clk);
    #1;
    if (bad) begin
      chk("flt_pulse", 32'(fault), 32'h1);
      chk("flt_addr", fault_addr, ad);
      chk("flt_wb_valid", 32'(wb_valid), 32'h0);
      chk("flt_mem_kept", tb_mem[idx], ref_mem[idx]);
      if (has_exp) chk("flt_addr_tbl", fault_addr, exp_val);
    end else if (!st) begin
      chk("ld_wb_valid", 32'(wb_valid), 32'h1);
      chk("ld_wb_is_load", 32'(wb_is_load), 32'h1);
      chk("ld_wb_data", wb_data, exp_ld);
      chk("ld_wb_rd_idx", 32'(wb_rd_idx), 32'(rd));
      chk("ld_fault", 32'(fault), 32'h0);
      if (has_exp) chk("ld_wb_data_tbl", wb_data, exp_val);
    end else if (sz == 2'b10) begin
      ref_mem[idx] = wd;
      chk("sw_wb_valid", 32'(wb_valid), 32'h1);
      chk("sw_wb_is_load", 32'(wb_is_load), 32'h0);
      chk("sw_wb_data", wb_data, 32'h0);
      chk("sw_wb_rd_idx", 32'(wb_rd_idx), 32'(rd));
      chk("sw_mem_word", tb_mem[idx], ref_mem[idx]);
      if (has_exp) chk("sw_mem_tbl", tb_mem[idx], exp_val);
    end else begin
      merged = ref_store(ref_mem[idx], sz, ad[1:0], wd);
      chk("rmwa_wb_valid", 32'(wb_valid), 32'h0);
      chk("rmwb_stall", 32'(stall), 32'h1);
      chk("rmwa_fault", 32'(fault), 32'h0);
      #3;
      chk("rmwb_mem_write", 32'(mem_write), 32'h1);
      chk("rmwb_mem_read", 32'(mem_read), 32'h0);
      chk("rmwb_mem_addr", 32'(mem_addr), 32'(idx));
      chk("rmwb_mem_wd", mem_wd, merged);
      @(posedge clk);
      #1;
      ref_mem[idx] = merged;
      chk("rmw_wb_valid", 32'(wb_valid), 32'h1);
      chk("rmw_wb_is_load", 32'(wb_is_load), 32'h0);
      chk("rmw_wb_data", wb_data, 32'h0);
      chk("rmw_wb_rd_idx", 32'(wb_rd_idx), 32'(rd));
      chk("rmw_stall_done", 32'(stall), 32'h0);
      chk("rmw_mem_word", tb_mem[idx], merged);
      if (has_exp) chk("rmw_mem_tbl", tb_mem[idx], exp_val);
    end
    req_valid = 1'b0;
    $display("txn %0d st=%0d sz=%0d un=%0d addr=%h wd=%h rd=%0d bad=%0d errs=%0d",
             txn_no, st, sz, un, ad, wd, rd, bad, txn_errs);
    txn_no++;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_stall"}, 32'(stall), 32'h0);
    chk({tag, "_wb_valid"}, 32'(wb_valid), 32'h0);
    chk({tag, "_wb_is_load"}, 32'(wb_is_load), 32'h0);
    chk({tag, "_wb_data"}, wb_data, 32'h0);
    chk({tag, "_wb_rd_idx"}, 32'(wb_rd_idx), 32'h0);
    chk({tag, "_fault"}, 32'(fault), 32'h0);
    chk({tag, "_fault_addr"}, fault_addr, 32'h0);
  endtask

  typedef struct {
    logic        st;
    logic [1:0]  sz;
    logic        un;
    logic [31:0] ad;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [31:0] exp_val;
  } vec_t;

  vec_t tbl [17];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    txn_no   = 0;

    rst          = 1'b1;
    req_valid    = 1'b0;
    req_is_store = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    req_rd_idx   = 5'h0;

    // Power-on reset.
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("por");
    #3;
    chk("por_mem_write", 32'(mem_write), 32'h0);
    chk("por_mem_read", 32'(mem_read), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Sweep: SW random words to every address, then LW them all back.
    for (int i = 0; i < 64; i++)
      issue(1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom, 5'($urandom_range(0, 31)), 1'b0, 32'h0);
    for (int i = 0; i < 64; i++)
      issue(1'b0, 2'b10, 1'b0, 32'(i * 4), 32'h0, 5'($urandom_range(0, 31)), 1'b0, 32'h0);

    // Directed vectors with hand-derived expected values.
    tbl[0]  = '{1'b1, 2'b10, 1'b0, 32'h10,  32'hDEADBEEF, 5'd1,  32'hDEADBEEF};
    tbl[1]  = '{1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        5'd2,  32'hDEADBEEF};
    tbl[2]  = '{1'b1, 2'b10, 1'b0, 32'h20,  32'h80FF7F01, 5'd3,  32'h80FF7F01};
    tbl[3]  = '{1'b0, 2'b00, 1'b0, 32'h20,  32'h0,        5'd4,  32'hFFFFFF80};
    tbl[4]  = '{1'b0, 2'b00, 1'b1, 32'h21,  32'h0,        5'd5,  32'h000000FF};
    tbl[5]  = '{1'b0, 2'b00, 1'b0, 32'h22,  32'h0,        5'd6,  32'h0000007F};
    tbl[6]  = '{1'b0, 2'b01, 1'b0, 32'h22,  32'h0,        5'd7,  32'h00007F01};
    tbl[7]  = '{1'b0, 2'b01, 1'b1, 32'h20,  32'h0,        5'd8,  32'h000080FF};
    tbl[8]  = '{1'b1, 2'b10, 1'b0, 32'h30,  32'h11223344, 5'd9,  32'h11223344};
    tbl[9]  = '{1'b1, 2'b00, 1'b0, 32'h31,  32'hAA,       5'd10, 32'h11AA3344};
    tbl[10] = '{1'b0, 2'b10, 1'b0, 32'h30,  32'h0,        5'd11, 32'h11AA3344};
    tbl[11] = '{1'b1, 2'b01, 1'b0, 32'h32,  32'hBEEF,     5'd12, 32'h11AABEEF};
    tbl[12] = '{1'b0, 2'b10, 1'b0, 32'h30,  32'h0,        5'd13, 32'h11AABEEF};
    tbl[13] = '{1'b0, 2'b10, 1'b0, 32'h31,  32'h0,        5'd14, 32'h31};
    tbl[14] = '{1'b1, 2'b01, 1'b0, 32'h05,  32'h1234,     5'd15, 32'h05};
    tbl[15] = '{1'b1, 2'b00, 1'b0, 32'h100, 32'h77,       5'd16, 32'h100};
    tbl[16] = '{1'b0, 2'b11, 1'b0, 32'h40,  32'h0,        5'd17, 32'h40};
    for (int i = 0; i < 17; i++)
      issue(tbl[i].st, tbl[i].sz, tbl[i].un, tbl[i].ad, tbl[i].wd, tbl[i].rd, 1'b1, tbl[i].exp_val);

    // Randomized mix of loads, stores and faults against the reference model.
    for (int i = 0; i < 150; i++) begin
      int unsigned r;
      logic [1:0]  sz;
      logic [31:0] ad;
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      ad = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) ad[0] = 1'b0;
        if (sz == 2'b10) ad[1:0] = 2'b00;
      end
      if ($urandom_range(0, 15) == 0) ad = ad | (32'h100 << $urandom_range(0, 23));
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom,
            5'($urandom_range(0, 31)), 1'b0, 32'h0);
    end

    // Reset arriving while a sub-word store sits in RMW_WR.
    issue(1'b0, 2'b10, 1'b0, 32'h34, 32'h0, 5'd21, 1'b0, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 32'h80, 32'h0, 5'd22, 1'b0, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h1F1, 32'h0, 5'd23, 1'b0, 32'h0);
    txn_errs     = 0;
    req_valid    = 1'b1;
    req_is_store = 1'b1;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h35;
    req_wdata    = 32'h5A;
    req_rd_idx   = 5'd24;
    @(posedge clk);
    #1;
    chk("rst_rmw_entered", 32'(stall), 32'h1);
    rst = 1'b1;
    #3;
    chk("rst_no_write", 32'(mem_write), 32'h0);
    chk("rst_no_read", 32'(mem_read), 32'h0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("rst_stall_cleared", 32'(stall), 32'h0);
    #3;
    chk("rst2_no_write", 32'(mem_write), 32'h0);
    @(posedge clk);
    #1;
    chk_reset_state("rmwrst");
    chk("rmwrst_mem_word", tb_mem[13], ref_mem[13]);
    $display("txn %0d reset-during-rmw addr=%h errs=%0d", txn_no, 32'h35, txn_errs);
    txn_no++;
    rst = 1'b0;
    issue(1'b0, 2'b10, 1'b0, 32'h34, 32'h0, 5'd25, 1'b0, 32'h0);
    issue(1'b0, 2'b00, 1'b1, 32'h35, 32'h0, 5'd26, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
